// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions.
// Instruction word type, JAL opcode and the bubble instruction.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam word_t      NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_jal.sv
// JAL predecode: opcode match and sign-extended J-immediate.
// Purely combinational.
module jal_predecode
  import fetch_stage_pkg::*;
(
  input  word_t instr,
  output logic  is_jal,
  output word_t imm
);

  assign is_jal = (instr[6:0] == OPCODE_JAL);

  assign imm = {{12{instr[31]}},
                instr[19:12],
                instr[20],
                instr[30:21],
                1'b0};

endmodule

// File: rtl/fetch_stage.sv
// Two-stage instruction fetch with skid buffer and JAL early redirect.
// Priority: redirect > stall > JAL > sequential.
module fetch_stage
  import fetch_stage_pkg::word_t;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = fetch_stage_pkg::NOP_INSTR
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_jal_addr
);

  word_t pc_q;
  word_t pc_1b;
  logic  valid_1b;
  word_t skid_q;
  logic  skid_full;

  word_t instr_1b;
  word_t jal_imm;
  word_t jal_sum;
  logic  is_jal;
  logic  take_jal;

  assign imem_addr = pc_q;

  // Memory re-reads the held PC during a stall, so 1b data lives in skid_q.
  assign instr_1b = skid_full ? skid_q : imem_rdata;

  jal_predecode u_predecode (
    .instr  (instr_1b),
    .is_jal (is_jal),
    .imm    (jal_imm)
  );

  assign take_jal = valid_1b & is_jal;
  assign jal_sum  = pc_1b + jal_imm;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pc_1b        <= '0;
      valid_1b     <= 1'b0;
      skid_q       <= NOP_INSTR;
      skid_full    <= 1'b0;
      out_valid    <= 1'b0;
      out_instr    <= NOP_INSTR;
      out_pc       <= '0;
      out_jal_addr <= '0;
    end else if (redirect_valid) begin
      pc_q      <= {redirect_addr[31:2], 2'b00};
      valid_1b  <= 1'b0;
      skid_full <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end else if (stall) begin
      if (!skid_full) begin
        skid_q    <= imem_rdata;
        skid_full <= 1'b1;
      end
    end else begin
      skid_full    <= 1'b0;
      out_valid    <= valid_1b;
      out_instr    <= valid_1b ? instr_1b : NOP_INSTR;
      out_pc       <= pc_1b;
      out_jal_addr <= pc_1b + 32'd4;
      pc_1b        <= pc_q;
      if (take_jal) begin
        pc_q     <= {jal_sum[31:2], 2'b00};
        valid_1b <= 1'b0;
      end else begin
        pc_q     <= pc_q + 32'd4;
        valid_1b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order model plus directed checks.
// Memory holds ADDI words except JALs at 0x8 and 0x210.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_jal_addr;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage #(
    .RESET_PC  (32'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_jal_addr   (out_jal_addr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8)   return 32'h010000EF;
    if (a == 32'h210) return 32'hF01FF0EF;
    return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  // Architectural successor of an instruction address.
  function automatic logic [31:0] succ(input logic [31:0] a);
    if (a == 32'h8)   return 32'h18;
    if (a == 32'h210) return 32'h110;
    return a + 32'd4;
  endfunction

  always @(posedge clock) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic        s_r, s_s, s_rv;
  logic [31:0] s_ra;
  logic [31:0] exp_next = 32'h0;
  logic        pv = 1'b0;
  logic [31:0] pp = 32'h0, pi = 32'h0, pj = 32'h0, pa = 32'h0;
  int          n_valid = 0;

  always begin
    @(posedge clock);
    s_r  = reset;
    s_s  = stall;
    s_rv = redirect_valid;
    s_ra = redirect_addr;
    #1;
    if (s_r) begin
      chk("m_rst_valid", 32'(out_valid), 32'h0);
      chk("m_rst_pc", out_pc, 32'h0);
      exp_next = 32'h0;
    end else if (s_rv) begin
      chk("m_rd_valid", 32'(out_valid), 32'h0);
      chk("m_rd_addr", imem_addr, s_ra & ~32'h3);
      exp_next = s_ra & ~32'h3;
    end else if (s_s) begin
      chk("m_hold_valid", 32'(out_valid), 32'(pv));
      chk("m_hold_pc", out_pc, pp);
      chk("m_hold_instr", out_instr, pi);
      chk("m_hold_jal", out_jal_addr, pj);
      chk("m_hold_addr", imem_addr, pa);
    end else if (out_valid) begin
      chk("m_order_pc", out_pc, exp_next);
      chk("m_instr", out_instr, mem_word(out_pc));
      chk("m_link", out_jal_addr, out_pc + 32'd4);
      exp_next = succ(out_pc);
      n_valid++;
    end
    if (!out_valid) chk("m_bubble_nop", out_instr, NOP);
    pv = out_valid;
    pp = out_pc;
    pi = out_instr;
    pj = out_jal_addr;
    pa = imem_addr;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("r_valid", 32'(out_valid), 32'h0);
    chk("r_instr", out_instr, NOP);
    chk("r_pc", out_pc, 32'h0);
    chk("r_jal", out_jal_addr, 32'h0);
    reset = 1'b0;
    chk("a_addr0", imem_addr, 32'h0);
    step(1);
    chk("a_addr4", imem_addr, 32'h4);
    chk("a_valid0", 32'(out_valid), 32'h0);
    step(1);
    chk("a_addr8", imem_addr, 32'h8);
    chk("a_valid1", 32'(out_valid), 32'h1);
    chk("a_pc0", out_pc, 32'h0);
    chk("a_link4", out_jal_addr, 32'h4);
    step(1);
    chk("a_addrC", imem_addr, 32'hC);
    chk("a_pc4", out_pc, 32'h4);
    step(1);
    chk("j_addr18", imem_addr, 32'h18);
    chk("j_pc8", out_pc, 32'h8);
    chk("j_link", out_jal_addr, 32'hC);
    chk("j_instr", out_instr, 32'h010000EF);
    step(1);
    chk("j_squash", 32'(out_valid), 32'h0);
    step(1);
    chk("j_tgt_pc", out_pc, 32'h18);

    do_reset();
    step(2);
    chk("s_pre_pc", out_pc, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s_frz_pc", out_pc, 32'h0);
      chk("s_frz_addr", imem_addr, 32'h8);
    end
    stall = 1'b0;
    step(1);
    chk("s_rel_pc", out_pc, 32'h4);
    chk("s_rel_instr", out_instr, 32'h00100093);
    step(1);
    chk("s_next_pc", out_pc, 32'h8);

    do_reset();
    step(3);
    stall = 1'b1;
    step(2);
    chk("k_frz_addr", imem_addr, 32'hC);
    chk("k_frz_pc", out_pc, 32'h4);
    stall = 1'b0;
    step(1);
    chk("k_jal_addr", imem_addr, 32'h18);
    chk("k_jal_pc", out_pc, 32'h8);
    step(1);
    chk("k_squash", 32'(out_valid), 32'h0);
    chk("k_no_dbl", imem_addr, 32'h1C);
    step(1);
    chk("k_tgt_pc", out_pc, 32'h18);

    stall = 1'b1;
    step(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    step(1);
    chk("d_addr", imem_addr, 32'h100);
    chk("d_valid0", 32'(out_valid), 32'h0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step(1);
    chk("d_valid1", 32'(out_valid), 32'h0);
    chk("d_addr2", imem_addr, 32'h104);
    step(1);
    chk("d_pc", out_pc, 32'h100);
    chk("d_instr", out_instr, 32'h04000093);

    redirect_valid = 1'b1;
    redirect_addr  = 32'h203;
    step(1);
    chk("e_align", imem_addr, 32'h200);
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (out_valid && out_pc == 32'h110) found = 1'b1;
    end
    chk("e_back_jal", 32'(found), 32'h1);

    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    step(1);
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step(1);
    chk("w_wrap", imem_addr, 32'h0);
    step(1);
    chk("w_pc_top", out_pc, 32'hFFFF_FFFC);
    step(1);
    chk("w_pc_zero", out_pc, 32'h0);

    stall = 1'b1;
    step(2);
    #2;
    reset = 1'b1;
    #1;
    chk("g_valid", 32'(out_valid), 32'h0);
    chk("g_instr", out_instr, NOP);
    chk("g_pc", out_pc, 32'h0);
    chk("g_jal", out_jal_addr, 32'h0);
    chk("g_addr", imem_addr, 32'h0);
    stall = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("g_rel_addr", imem_addr, 32'h0);
    step(1);
    chk("g_addr4", imem_addr, 32'h4);
    step(4);
    chk("z_progress", 32'(n_valid > 20), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction presented when output is invalid.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: stall  input  1  hazard hold from the bypass unit; freezes fetch.
REQ-007 Port: redirect_valid  input  1  stage-3 branch/JALR flush request.
REQ-008 Port: redirect_addr  input  32  stage-3 target address.
REQ-009 Port: imem_addr  output  32  instruction-memory address (stage 1a PC).
REQ-010 Port: imem_rdata  input  32  synchronous memory data, valid one cycle after imem_addr.
REQ-011 Port: out_valid  output  1  the stage-2 instruction is live.
REQ-012 Port: out_instr  output  32  stage-2 instruction word.
REQ-013 Port: out_pc  output  32  stage-2 instruction address.
REQ-014 Port: out_jal_addr  output  32  out_pc + 4 link value, for the rd write.

Function
REQ-015 Pipeline: 1a register pc_q drives imem_addr combinationally; 1b register holds pc_1b/valid_1b; the stage-2 output register is loaded from 1b; fetch-to-output latency SHALL be 2 cycles.
REQ-016 With no stall, redirect or JAL: pc_q <= pc_q + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 JAL early redirect: valid_1b and imem_rdata[6:0] = 7'b1101111, with no stall and no redirect -> pc_q <= pc_1b + sign-extended J-immediate; valid_1b <= 0 for the squashed sequential slot.
REQ-018 Redirect priority: redirect_valid > stall > JAL > sequential.
REQ-019 Redirect: pc_q <= redirect_addr, valid_1b <= 0, out_valid <= 0 on the same edge, regardless of stall.
REQ-020 Stall without redirect: pc_q, pc_1b, valid_1b and all outputs SHALL hold.
REQ-021 Skid buffer: on the first stall cycle, capture imem_rdata into skid_q and set skid_full.
REQ-022 On the first non-stall cycle after a stall, load the stage-2 instruction from skid_q, then clear skid_full.
REQ-023 A redirect SHALL clear skid_full.
REQ-024 When out_valid = 0, out_instr = NOP_INSTR.
REQ-025 Targets from redirect and JAL SHALL have bits [1:0] forced to 0.
REQ-026 Simultaneous redirect and stall: apply the redirect; the stall applies to the next fetch only.
REQ-027 A JAL in 1b during a stall SHALL be evaluated using skid_q once the stall releases, with no double redirect.

Reset
REQ-028 Assertion of reset, including mid-stall, mid-skid or mid-redirect, SHALL asynchronously set:
  - pc_q = RESET_PC
  - pc_1b = 0, valid_1b = 0
  - skid_full = 0, skid_q = NOP_INSTR
  - out_valid = 0, out_instr = NOP_INSTR, out_pc = 0, out_jal_addr = 0
REQ-029 The first imem_addr after reset release SHALL be RESET_PC, and the first out_valid = 1 SHALL occur 2 cycles after release.

Structure
REQ-030 The shared definitions package SHALL hold the word typedef, OPCODE_JAL and NOP_INSTR.
REQ-031 J-immediate extraction SHALL be a combinational sub-module, jal_predecode: instr in; is_jal and imm out.

Verification
REQ-032 Reset release, RESET_PC=0, memory returning ADDI words, no stalls -> imem_addr 0,4,8…; out_valid rises in cycle 2 with out_pc=0, then out_pc=4.
REQ-033 JAL +16 at 0x8 -> imem_addr sequence 0x8, 0xC, 0x18; the 0xC slot never reaches out_valid; out_jal_addr=0xC when out_pc=0x8.
REQ-034 Stall held 3 cycles while 1b holds 0x4 -> outputs frozen; after release out_instr equals the word at 0x4 from skid_q; no instruction dropped or duplicated.
REQ-035 redirect_valid with stall, redirect_addr=0x100 -> next imem_addr=0x100; out_valid=0 for 2 cycles; skid_full cleared.
REQ-036 Start from pc_q=0xFFFF_FFFC -> next imem_addr=0x0.
REQ-037 Reset asserted mid-stall with skid_full=1 -> all outputs immediately take their reset values; after release the first imem_addr = RESET_PC.
